sub_serial: RTL
===============

SUB_SERIAL -- requirements
Module: sub_serial

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, number of 4-bit slices; operand width W = 4*NIBBLES.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand set offered.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand set.
REQ-006 SHALL have port a  input  W  minuend.
REQ-007 SHALL have port b  input  W  subtrahend.
REQ-008 SHALL have port b_in  input  1  borrow-in, subtracted at bit 0.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port diff  output  W  a - b - b_in, modulo 2^W.
REQ-012 SHALL have port b_out  output  1  borrow out of the MSB.
REQ-013 SHALL have port zero  output  1  diff equals 0.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 IDLE: on edge with in_valid=1, SHALL latch a, b, b_in into registers, clear slice index to 0, go to BUSY.
REQ-017 BUSY: each cycle SHALL subtract one 4-bit nibble (LSB nibble first) using the registered borrow chain; borrow into nibble 0 is latched b_in.
REQ-018 BUSY SHALL last exactly NIBBLES cycles; after the edge processing the last nibble SHALL go to DONE.
REQ-019 Latency: operands accepted at edge k SHALL give out_valid=1 after edge k+NIBBLES+... no: after edge k+NIBBLES exactly.
REQ-020 DONE: diff, b_out, zero SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 DONE with out_ready=1 SHALL return to IDLE on that edge; no same-edge accept of new operands (one idle cycle minimum between results).
REQ-022 in_valid, a, b, b_in changes during BUSY/DONE SHALL be ignored.
REQ-023 Arithmetic SHALL be unsigned; b_out=1 iff a < b + b_in as unsigned integers.
REQ-024 zero SHALL reflect the final diff value presented (after saturation if enabled).

Reset
REQ-025 rst=1 SHALL asynchronously force state IDLE, slice index 0, borrow chain 0, diff=0, b_out=0, zero=0, out_valid=0; in_ready=1 once in IDLE.
REQ-026 Reset during BUSY or DONE SHALL discard the in-flight operation with no output pulse.

Configuration
REQ-027 Macro SUB_SERIAL_SAT_EN defined: when final b_out=1, diff SHALL be forced to 0 and zero=1; b_out still reported as 1.
REQ-028 Macro SUB_SERIAL_SAT_EN undefined: diff SHALL be the modulo-2^W wrap-around result.

Structure
REQ-029 Shared package sub_pkg SHALL hold the FSM state enum (IDLE, BUSY, DONE) and constant NIBBLE_W=4.
REQ-030 One combinational sub-module sub_4b SHALL compute a 4-bit nibble difference and borrow-out from (a, b, borrow-in); sub_serial SHALL instantiate exactly one.

Verification
REQ-031 a=0x1234, b=0x0234, b_in=0 -> after 4 cycles diff=0x1000, b_out=0, zero=0.
REQ-032 a=0x0000, b=0x0001, b_in=0 -> diff=0xFFFF, b_out=1 (SAT_EN: diff=0x0000, zero=1).
REQ-033 a=0xFFFF, b=0xFFFF, b_in=1 -> diff=0xFFFF, b_out=1; a=0xA5A5, b=0xA5A5, b_in=0 -> diff=0, zero=1, b_out=0.
REQ-034 out_ready held 0 for 10 cycles in DONE -> out_valid and diff held constant; in_valid pulses with new operands ignored.
REQ-035 rst asserted at second BUSY cycle -> outputs zero immediately, in_ready=1 after release, next operation 0x0010-0x0001 gives 0x000F.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared definitions for the nibble-serial subtractor: FSM state encoding and slice width.
package sub_pkg;
    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/sub_4b.sv
// Combinational 4-bit subtract slice: diff = a - b - b_in, with borrow out of bit 3.
module sub_4b
    import sub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                b_in,
    output logic [NIBBLE_W-1:0] diff,
    output logic                b_out
);
    logic [NIBBLE_W:0] full;

    // The extra top bit of the widened difference is exactly the borrow out.
    assign full  = {1'b0, a} - {1'b0, b} - {{NIBBLE_W{1'b0}}, b_in};
    assign diff  = full[NIBBLE_W-1:0];
    assign b_out = full[NIBBLE_W];
endmodule

// File: rtl/sub_serial.sv
// Nibble-serial unsigned subtractor (diff = a - b - b_in) with valid/ready handshakes.
// Optional build macro SUB_SERIAL_SAT_EN clamps an underflowing result to zero.
module sub_serial
    import sub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                        b_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] diff,
    output logic                        b_out,
    output logic                        zero
);
    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     diff_q, diff_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             borrow_q, borrow_d;
    logic             b_out_q, b_out_d;
    logic             zero_q, zero_d;

    logic [NIBBLE_W-1:0] nib_diff;
    logic                nib_borrow;

    // Operands shift right each BUSY cycle, so the live nibble is always the low slice.
    sub_4b u_sub_4b (
        .a     (a_q[NIBBLE_W-1:0]),
        .b     (b_q[NIBBLE_W-1:0]),
        .b_in  (borrow_q),
        .diff  (nib_diff),
        .b_out (nib_borrow)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        b_out_d  = b_out_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = b_in;
                    idx_d    = '0;
                    diff_d   = '0;
                    b_out_d  = 1'b0;
                    zero_d   = 1'b0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                // Result nibbles enter at the top and migrate down, LSB nibble landing last at bit 0.
                a_d      = a_q >> NIBBLE_W;
                b_d      = b_q >> NIBBLE_W;
                borrow_d = nib_borrow;
                diff_d   = (diff_q >> NIBBLE_W) | (W'(nib_diff) << (W - NIBBLE_W));
                idx_d    = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    b_out_d = nib_borrow;
`ifdef SUB_SERIAL_SAT_EN
                    if (nib_borrow) begin
                        diff_d = '0;
                    end
`endif
                    zero_d  = (diff_d == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            b_out_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            b_out_q  <= b_out_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign b_out     = b_out_q;
    assign zero      = zero_q;
endmodule
